// File: rtl/seg_page_ctrl.sv
// Page controller for the 5-digit seven-segment display: debounced page key,
// page rotation, and scheduling of one shared binary-to-BCD converter.
module seg_page_ctrl #(
  parameter int DEB_CYC     = 1_000_000,
  parameter int REFRESH_CYC = 5_000_000,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  input  logic [3:0]  num3,
  output logic        conv_start,
  output logic [15:0] conv_bin,
  input  logic        conv_done,
  input  logic [19:0] conv_bcd,
  output logic [2:0]  page,
  output logic [19:0] disp_bcd,
  output logic        disp_valid
);

  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic          key_s1, key_s2, key_state, press;
  logic [DW-1:0] deb_cnt;
  logic [RW-1:0] ref_cnt;
  logic          trig;
  logic [2:0]    next_page;
  logic [0:0]    state;
  logic [2:0]    issue_page;
  logic          pending;
  logic [TW-1:0] to_cnt;

  // The counter only runs while the synchronized level differs from the
  // accepted level, so any bounce back to the accepted level clears it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_state <= 1'b1;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
      press  <= 1'b0;
      if (key_s2 != key_state) begin
        if (deb_cnt == DEB_LAST) begin
          key_state <= key_s2;
          deb_cnt   <= '0;
          press     <= ~key_s2;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign next_page = {page[1:0], page[2]};

  // A press always takes precedence over a refresh expiry in the same cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      page    <= 3'b001;
      ref_cnt <= '0;
      trig    <= 1'b0;
    end else begin
      trig <= 1'b0;
      if (press) begin
        page    <= next_page;
        ref_cnt <= '0;
        trig    <= ~next_page[0];
      end else if (page[0]) begin
        ref_cnt <= '0;
      end else if (ref_cnt == REF_LAST) begin
        ref_cnt <= '0;
        trig    <= 1'b1;
      end else begin
        ref_cnt <= ref_cnt + RW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      conv_start <= 1'b0;
      conv_bin   <= '0;
      issue_page <= 3'b001;
      pending    <= 1'b0;
      to_cnt     <= '0;
      disp_bcd   <= '0;
      disp_valid <= 1'b1;
    end else begin
      conv_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!page[0] && (trig || pending)) begin
            conv_start <= 1'b1;
            conv_bin   <= page[1] ? num1 : num2;
            issue_page <= page;
            pending    <= 1'b0;
            to_cnt     <= '0;
            state      <= ST_WAIT;
          end else if (page[0]) begin
            pending <= 1'b0;
          end
        end
        default: begin
          if (trig) pending <= 1'b1;
          if (conv_done) begin
            state <= ST_IDLE;
            if (issue_page == page) begin
              disp_bcd   <= conv_bcd;
              disp_valid <= 1'b1;
            end else if (!page[0]) begin
              pending <= 1'b1;
            end
          end else if (to_cnt == TO_LAST) begin
            state <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
      endcase

      // Page changes override any result landing on the same edge.
      if (press) begin
        if (next_page[0]) begin
          disp_bcd   <= {16'h0000, num3};
          disp_valid <= 1'b1;
        end else begin
          disp_valid <= 1'b0;
        end
      end else if (page[0]) begin
        disp_bcd   <= {16'h0000, num3};
        disp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg_page_ctrl.md
Name: seg_page_ctrl

Overview:
- Display-page controller in front of the 5-digit seven-segment driver.
- Debounces the page key and selects the active page (wr_done code, waveA frequency, waveB frequency).
- Schedules one shared serial binary-to-BCD converter through a start/done handshake, and delivers a stable 5-digit BCD word to the scan driver.
- Replaces per-digit divide/modulo logic with a single time-shared converter.

Parameters:
DEB_CYC, 1_000_000, key must be stable this many sys_clk cycles to register (20 ms at 50 MHz)
REFRESH_CYC, 5_000_000, period between periodic re-conversions of the active frequency page (100 ms)
TIMEOUT_CYC, 64, maximum cycles to wait for conv_done before abandoning a request

Ports:
sys_clk  in  1  system clock, single clock domain
sys_rst_n  in  1  asynchronous active-low reset
key  in  1  raw page key, active-low, asynchronous to sys_clk
num1  in  16  waveA frequency, binary, 0..65535
num2  in  16  waveB frequency, binary, 0..65535
num3  in  4  wr_done code, shown raw on the last digit
conv_start  out  1  one-cycle request pulse to the BCD converter
conv_bin  out  16  operand to the converter, held stable from conv_start until conv_done
conv_done  in  1  one-cycle completion pulse from the converter
conv_bcd  in  20  converter result, 5 BCD digits, MSD at [19:16], valid while conv_done=1
page  out  3  one-hot page: 001 = wr_done, 010 = num1, 100 = num2
disp_bcd  out  20  digits for the scan driver, MSD at [19:16]
disp_valid  out  1  disp_bcd matches the current page

Behaviour:
- Reset values: conv_start=0, conv_bin=0, page=001, disp_bcd=20'h00000, disp_valid=1, FSM=IDLE, all counters=0, pending=0.
- Key path:
  - 2-FF synchronizer on key, then a debounce counter that clears on any change of the synchronized level.
  - When the synchronized key has been low for DEB_CYC consecutive cycles, generate exactly one press pulse.
  - No further press pulse until the key has been stable high for DEB_CYC cycles.
- Page: on a press pulse, rotate left: 001→010→100→001. page is never anything other than one-hot.
- Page 001: disp_bcd = {16'h0000, num3}, updated every cycle, disp_valid=1. No conversions are issued.
- Entering page 010 or 100:
  - disp_valid=0 on the same edge that page changes.
  - The refresh timer restarts.
  - A conversion trigger is raised.
- Refresh timer: counts only on pages 010/100 and raises a trigger at REFRESH_CYC-1, then wraps to 0.
- FSM states and transitions:
  - IDLE: on a trigger or pending, with page != 001:
    - conv_bin = num1 (page 010) or num2 (page 100), captured as a snapshot.
    - conv_start=1 for exactly one cycle.
    - Record the issuing page, clear pending, go to WAIT.
  - WAIT: conv_start=0, conv_bin held. Timeout counter increments.
    - On conv_done with the issuing page equal to the current page: disp_bcd<=conv_bcd, disp_valid<=1, go to IDLE.
    - On conv_done with a different page: discard the result, set pending if the current page != 001, go to IDLE.
    - At TIMEOUT_CYC cycles without conv_done: go to IDLE, keep disp_bcd and disp_valid, no retry until the next trigger.
- Triggers arriving while in WAIT are absorbed into pending; at most one request is outstanding.
- Press pulse and refresh expiry on the same cycle: the page change wins and only one conversion is issued, for the new page.
- conv_done while in IDLE (spurious): ignored.
- Latency: press pulse → conv_start is 2 cycles (trigger registered, then IDLE issue). conv_done → disp_bcd/disp_valid update is 1 cycle.
- Reset mid-WAIT: immediately returns to reset values; a late conv_done is ignored.

Test Plan:
(Simulation uses DEB_CYC=8, REFRESH_CYC=200, TIMEOUT_CYC=16; converter model replies 5 cycles after conv_start.)
- Key low for 5 cycles then high (bounce) → no press, page stays 001, disp_bcd=20'h00003 with num3=3.
- Key low for 20 cycles, num1=12345 → page=010, disp_valid drops to 0, one conv_start with conv_bin=12345, disp_bcd=20'h12345 and disp_valid=1 a cycle after conv_done.
- On page 010, num1 changes to 500 → within 200 cycles a new conv_start with conv_bin=500, disp_bcd=20'h00500.
- Second press issued 2 cycles after conv_start on page 010, num2=65535 → the num1 result is discarded, a re-issue carries conv_bin=65535, final disp_bcd=20'h65535 on page 100.
- Converter model silent → conv_start, then a return to IDLE after 16 cycles with disp_bcd unchanged; the next refresh issues a fresh request.
- Third press → page=001, disp_bcd=20'h0000{num3}; reset asserted mid-WAIT → page=001, conv_start=0, disp_valid=1.
